// File: rtl/snax_acc_csr_responder.sv
// Accelerator-offload responder: decodes offloaded CSR instructions, holds config CSRs and a
// start/status CSR, and returns tagged read responses through a registered FIFO.
module snax_acc_csr_responder #(
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned NumCsr        = 8,
  parameter logic [11:0] CsrAddrOffset = 12'h3C0,
  parameter int unsigned RspFifoDepth  = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            acc_qvalid_i,
  output logic                            acc_qready_o,
  input  logic [4:0]                      acc_qid_i,
  input  logic [31:0]                     acc_qdata_op_i,
  input  logic [DataWidth-1:0]            acc_qdata_arga_i,
  output logic                            acc_pvalid_o,
  input  logic                            acc_pready_i,
  output logic [4:0]                      acc_pid_o,
  output logic                            acc_perror_o,
  output logic [DataWidth-1:0]            acc_pdata_o,
  output logic [(NumCsr-1)*DataWidth-1:0] csr_o,
  output logic                            start_o,
  input  logic                            acc_busy_i
);

  localparam int unsigned NumCfg    = NumCsr - 1;
  localparam int unsigned PtrW      = (RspFifoDepth > 1) ? $clog2(RspFifoDepth) : 1;
  localparam int unsigned CntW      = $clog2(RspFifoDepth + 1);
  localparam logic [11:0] StatusIdx = 12'(NumCsr - 1);
  localparam logic [11:0] NumCsrW   = 12'(NumCsr);

  typedef struct packed {
    logic [4:0]           id;
    logic                 error;
    logic [DataWidth-1:0] data;
  } rsp_t;

  // Request decode
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [11:0] csr_addr;
  logic [11:0] idx;
  logic        in_range, is_status, is_write, is_read;
  logic        req_fire, push, pop, full, empty;
  logic        unused_rd;

  assign opcode    = acc_qdata_op_i[6:0];
  assign funct3    = acc_qdata_op_i[14:12];
  assign rs1       = acc_qdata_op_i[19:15];
  assign csr_addr  = acc_qdata_op_i[31:20];
  assign unused_rd = ^acc_qdata_op_i[11:7];
  assign idx       = csr_addr - CsrAddrOffset;
  assign in_range  = (csr_addr >= CsrAddrOffset) && (idx < NumCsrW);
  assign is_status = in_range && (idx == StatusIdx);
  assign is_write  = (opcode == 7'h73) && (funct3 == 3'b001);
  assign is_read   = (opcode == 7'h73) && (funct3 == 3'b010) && (rs1 == 5'd0);

  logic start_q, start_d;

  // Full blocks only responding requests; writes never push, so they may pass a full FIFO.
  always_comb begin
    acc_qready_o = 1'b1;
    if (!is_write && full) acc_qready_o = 1'b0;
    if (is_write && (acc_busy_i || start_q)) acc_qready_o = 1'b0;
  end

  assign req_fire = acc_qvalid_i && acc_qready_o;
  assign start_d  = req_fire && is_write && is_status && acc_qdata_arga_i[0];

  // Config CSR bank
  logic [DataWidth-1:0] csr_q [NumCfg];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumCfg; i++) csr_q[i] <= '0;
      start_q <= 1'b0;
    end else begin
      for (int i = 0; i < NumCfg; i++) begin
        if (req_fire && is_write && in_range && (idx == 12'(i))) csr_q[i] <= acc_qdata_arga_i;
      end
      start_q <= start_d;
    end
  end

  for (genvar g = 0; g < NumCfg; g++) begin : g_csr_out
    assign csr_o[g*DataWidth +: DataWidth] = csr_q[g];
  end

  assign start_o = start_q;

  // Response formation
  rsp_t rsp_d;

  always_comb begin
    rsp_d    = '0;
    rsp_d.id = acc_qid_i;
    if (is_read && in_range) begin
      if (is_status) begin
        rsp_d.data = {{(DataWidth-1){1'b0}}, acc_busy_i | start_q};
      end else begin
        for (int i = 0; i < NumCfg; i++) begin
          if (idx == 12'(i)) rsp_d.data = csr_q[i];
        end
      end
    end else begin
      rsp_d.error = 1'b1;
    end
  end

  // Response FIFO
  rsp_t            mem_q [RspFifoDepth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q;
  rsp_t            head;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(RspFifoDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (cnt_q == CntW'(RspFifoDepth));
  assign empty = (cnt_q == '0);
  assign push  = req_fire && !is_write;
  assign pop   = !empty && acc_pready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < RspFifoDepth; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= rsp_d;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head         = mem_q[rd_ptr_q];
  assign acc_pvalid_o = !empty;
  assign acc_pid_o    = empty ? 5'd0 : head.id;
  assign acc_perror_o = empty ? 1'b0 : head.error;
  assign acc_pdata_o  = empty ? '0 : head.data;

endmodule

// File: tb/tb_snax_acc_csr_responder.sv
// Directed bench for snax_acc_csr_responder: CSR write/read, start/busy interlock, errors,
// response backpressure, back-to-back streaming and asynchronous reset.
module tb_snax_acc_csr_responder;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         acc_qvalid_i;
  logic         acc_qready_o;
  logic [4:0]   acc_qid_i;
  logic [31:0]  acc_qdata_op_i;
  logic [31:0]  acc_qdata_arga_i;
  logic         acc_pvalid_o;
  logic         acc_pready_i;
  logic [4:0]   acc_pid_o;
  logic         acc_perror_o;
  logic [31:0]  acc_pdata_o;
  logic [223:0] csr_o;
  logic         start_o;
  logic         acc_busy_i;

  int passed = 0;
  int total  = 0;

  always #5 clk_i = ~clk_i;

  snax_acc_csr_responder dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .acc_qvalid_i     (acc_qvalid_i),
    .acc_qready_o     (acc_qready_o),
    .acc_qid_i        (acc_qid_i),
    .acc_qdata_op_i   (acc_qdata_op_i),
    .acc_qdata_arga_i (acc_qdata_arga_i),
    .acc_pvalid_o     (acc_pvalid_o),
    .acc_pready_i     (acc_pready_i),
    .acc_pid_o        (acc_pid_o),
    .acc_perror_o     (acc_perror_o),
    .acc_pdata_o      (acc_pdata_o),
    .csr_o            (csr_o),
    .start_o          (start_o),
    .acc_busy_i       (acc_busy_i)
  );

  function automatic logic [31:0] rd_op(input logic [11:0] c);
    return {c, 5'd0, 3'b010, 5'd1, 7'h73};
  endfunction

  function automatic logic [31:0] wr_op(input logic [11:0] c);
    return {c, 5'd2, 3'b001, 5'd0, 7'h73};
  endfunction

  task automatic present(input logic v, input logic [31:0] op, input logic [4:0] id,
                         input logic [31:0] a);
    acc_qvalid_i     = v;
    acc_qdata_op_i   = op;
    acc_qid_i        = id;
    acc_qdata_arga_i = a;
  endtask

  task automatic test_reset;
    total++; if (acc_pvalid_o !== 1'b0) $display("FAIL rst_pvalid got %0b exp 0", acc_pvalid_o); else passed++;
    total++; if (acc_pid_o !== 5'd0) $display("FAIL rst_pid got %0d exp 0", acc_pid_o); else passed++;
    total++; if (acc_perror_o !== 1'b0) $display("FAIL rst_perror got %0b exp 0", acc_perror_o); else passed++;
    total++; if (acc_pdata_o !== 32'd0) $display("FAIL rst_pdata got %h exp 0", acc_pdata_o); else passed++;
    total++; if (csr_o !== 224'd0) $display("FAIL rst_csr got %h exp 0", csr_o); else passed++;
    total++; if (start_o !== 1'b0) $display("FAIL rst_start got %0b exp 0", start_o); else passed++;
    total++; if (acc_qready_o !== 1'b1) $display("FAIL rst_qready got %0b exp 1", acc_qready_o); else passed++;
  endtask

  task automatic test_write_read;
    acc_pready_i = 1'b0;
    present(1'b1, wr_op(12'h3C1), 5'd0, 32'hDEAD_BEEF);
    #1;
    total++; if (acc_qready_o !== 1'b1) $display("FAIL wr_qready got %0b exp 1", acc_qready_o); else passed++;
    @(negedge clk_i);
    total++; if (csr_o[63:32] !== 32'hDEAD_BEEF) $display("FAIL wr_csr1 got %h exp deadbeef", csr_o[63:32]); else passed++;
    total++; if (acc_pvalid_o !== 1'b0) $display("FAIL wr_noresp got %0b exp 0", acc_pvalid_o); else passed++;
    present(1'b1, rd_op(12'h3C1), 5'd5, 32'd0);
    @(negedge clk_i);
    present(1'b0, 32'd0, 5'd0, 32'd0);
    total++; if (acc_pvalid_o !== 1'b1) $display("FAIL rd_pvalid got %0b exp 1", acc_pvalid_o); else passed++;
    total++; if (acc_pid_o !== 5'd5) $display("FAIL rd_pid got %0d exp 5", acc_pid_o); else passed++;
    total++; if (acc_perror_o !== 1'b0) $display("FAIL rd_perror got %0b exp 0", acc_perror_o); else passed++;
    total++; if (acc_pdata_o !== 32'hDEAD_BEEF) $display("FAIL rd_pdata got %h exp deadbeef", acc_pdata_o); else passed++;
    @(negedge clk_i);
    total++; if (acc_pdata_o !== 32'hDEAD_BEEF) $display("FAIL rd_hold got %h exp deadbeef", acc_pdata_o); else passed++;
    acc_pready_i = 1'b1;
    @(negedge clk_i);
    total++; if (acc_pvalid_o !== 1'b0) $display("FAIL rd_popped got %0b exp 0", acc_pvalid_o); else passed++;
  endtask

  task automatic test_start;
    present(1'b1, wr_op(12'h3C7), 5'd0, 32'd1);
    @(negedge clk_i);
    total++; if (start_o !== 1'b1) $display("FAIL start_hi got %0b exp 1", start_o); else passed++;
    present(1'b1, wr_op(12'h3C6), 5'd0, 32'h0000_00A5);
    #1;
    total++; if (acc_qready_o !== 1'b0) $display("FAIL start_blocks_wr got %0b exp 0", acc_qready_o); else passed++;
    @(negedge clk_i);
    total++; if (start_o !== 1'b0) $display("FAIL start_lo got %0b exp 0", start_o); else passed++;
    total++; if (acc_qready_o !== 1'b1) $display("FAIL start_release got %0b exp 1", acc_qready_o); else passed++;
    @(negedge clk_i);
    present(1'b0, 32'd0, 5'd0, 32'd0);
    total++; if (csr_o[223:192] !== 32'hA5) $display("FAIL csr6 got %h exp a5", csr_o[223:192]); else passed++;
    total++; if (start_o !== 1'b0) $display("FAIL start_once got %0b exp 0", start_o); else passed++;
  endtask

  task automatic test_errors;
    acc_busy_i   = 1'b1;
    acc_pready_i = 1'b1;
    present(1'b1, rd_op(12'h3C7), 5'd7, 32'd0);
    @(negedge clk_i);
    total++; if ({acc_pvalid_o, acc_pid_o, acc_perror_o, acc_pdata_o} !== {1'b1, 5'd7, 1'b0, 32'd1})
      $display("FAIL status_rd got v%0b id%0d e%0b d%h exp v1 id7 e0 d1",
               acc_pvalid_o, acc_pid_o, acc_perror_o, acc_pdata_o); else passed++;
    present(1'b1, rd_op(12'h3C8), 5'd8, 32'd0);
    @(negedge clk_i);
    total++; if ({acc_pvalid_o, acc_pid_o, acc_perror_o, acc_pdata_o} !== {1'b1, 5'd8, 1'b1, 32'd0})
      $display("FAIL oor_rd got v%0b id%0d e%0b d%h exp v1 id8 e1 d0",
               acc_pvalid_o, acc_pid_o, acc_perror_o, acc_pdata_o); else passed++;
    present(1'b1, 32'h0000_0033, 5'd3, 32'd0);
    @(negedge clk_i);
    total++; if ({acc_pvalid_o, acc_pid_o, acc_perror_o, acc_pdata_o} !== {1'b1, 5'd3, 1'b1, 32'd0})
      $display("FAIL illegal got v%0b id%0d e%0b d%h exp v1 id3 e1 d0",
               acc_pvalid_o, acc_pid_o, acc_perror_o, acc_pdata_o); else passed++;
    present(1'b1, rd_op(12'h3BF), 5'd4, 32'd0);
    @(negedge clk_i);
    present(1'b0, 32'd0, 5'd0, 32'd0);
    total++; if ({acc_pid_o, acc_perror_o} !== {5'd4, 1'b1})
      $display("FAIL below_rd got id%0d e%0b exp id4 e1", acc_pid_o, acc_perror_o); else passed++;
    @(negedge clk_i);
    total++; if (acc_pvalid_o !== 1'b0) $display("FAIL err_drain got %0b exp 0", acc_pvalid_o); else passed++;
  endtask

  task automatic test_busy_write;
    present(1'b1, rd_op(12'h3C0), 5'd9, 32'd0);
    #1;
    total++; if (acc_qready_o !== 1'b1) $display("FAIL busy_rd_ready got %0b exp 1", acc_qready_o); else passed++;
    @(negedge clk_i);
    total++; if ({acc_pid_o, acc_pdata_o} !== {5'd9, 32'd0})
      $display("FAIL busy_rd got id%0d d%h exp id9 d0", acc_pid_o, acc_pdata_o); else passed++;
    present(1'b1, wr_op(12'h3C0), 5'd0, 32'h1234_5678);
    #1;
    total++; if (acc_qready_o !== 1'b0) $display("FAIL busy_wr_stall got %0b exp 0", acc_qready_o); else passed++;
    @(negedge clk_i);
    total++; if (acc_qready_o !== 1'b0) $display("FAIL busy_wr_stall2 got %0b exp 0", acc_qready_o); else passed++;
    total++; if (csr_o[31:0] !== 32'd0) $display("FAIL busy_csr0 got %h exp 0", csr_o[31:0]); else passed++;
    acc_busy_i = 1'b0;
    #1;
    total++; if (acc_qready_o !== 1'b1) $display("FAIL idle_wr_ready got %0b exp 1", acc_qready_o); else passed++;
    @(negedge clk_i);
    present(1'b0, 32'd0, 5'd0, 32'd0);
    total++; if (csr_o[31:0] !== 32'h1234_5678) $display("FAIL csr0 got %h exp 12345678", csr_o[31:0]); else passed++;
  endtask

  task automatic test_backpressure;
    acc_pready_i = 1'b0;
    present(1'b1, rd_op(12'h3C1), 5'd1, 32'd0);
    @(negedge clk_i);
    present(1'b1, rd_op(12'h3C1), 5'd2, 32'd0);
    #1;
    total++; if (acc_qready_o !== 1'b1) $display("FAIL bp_second_ready got %0b exp 1", acc_qready_o); else passed++;
    @(negedge clk_i);
    present(1'b1, rd_op(12'h3C1), 5'd3, 32'd0);
    #1;
    total++; if (acc_qready_o !== 1'b0) $display("FAIL bp_full got %0b exp 0", acc_qready_o); else passed++;
    @(negedge clk_i);
    total++; if (acc_pid_o !== 5'd1) $display("FAIL bp_head got %0d exp 1", acc_pid_o); else passed++;
    acc_pready_i = 1'b1;
    #1;
    total++; if (acc_qready_o !== 1'b0) $display("FAIL bp_full_pop got %0b exp 0", acc_qready_o); else passed++;
    @(negedge clk_i);
    total++; if (acc_pid_o !== 5'd2) $display("FAIL bp_order2 got %0d exp 2", acc_pid_o); else passed++;
    total++; if (acc_qready_o !== 1'b1) $display("FAIL bp_reopen got %0b exp 1", acc_qready_o); else passed++;
    @(negedge clk_i);
    present(1'b0, 32'd0, 5'd0, 32'd0);
    total++; if ({acc_pvalid_o, acc_pid_o, acc_pdata_o} !== {1'b1, 5'd3, 32'hDEAD_BEEF})
      $display("FAIL bp_order3 got v%0b id%0d d%h exp v1 id3 ddeadbeef",
               acc_pvalid_o, acc_pid_o, acc_pdata_o); else passed++;
    @(negedge clk_i);
    total++; if (acc_pvalid_o !== 1'b0) $display("FAIL bp_nodup got %0b exp 0", acc_pvalid_o); else passed++;
  endtask

  task automatic test_back_to_back;
    acc_pready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      present(1'b1, rd_op(12'h3C1), 5'(10 + k), 32'd0);
      #1;
      total++; if (acc_qready_o !== 1'b1) $display("FAIL b2b_ready%0d got %0b exp 1", k, acc_qready_o); else passed++;
      @(negedge clk_i);
      total++; if ({acc_pvalid_o, acc_pid_o} !== {1'b1, 5'(10 + k)})
        $display("FAIL b2b_rsp%0d got v%0b id%0d exp v1 id%0d", k, acc_pvalid_o, acc_pid_o, 10 + k);
      else passed++;
    end
    present(1'b0, 32'd0, 5'd0, 32'd0);
    @(negedge clk_i);
    total++; if (acc_pvalid_o !== 1'b0) $display("FAIL b2b_drain got %0b exp 0", acc_pvalid_o); else passed++;
  endtask

  task automatic test_async_reset;
    acc_pready_i = 1'b0;
    present(1'b1, rd_op(12'h3C1), 5'd20, 32'd0);
    @(negedge clk_i);
    present(1'b1, rd_op(12'h3C1), 5'd21, 32'd0);
    @(negedge clk_i);
    present(1'b1, wr_op(12'h3C7), 5'd0, 32'd1);
    #1;
    total++; if (acc_qready_o !== 1'b1) $display("FAIL ar_wr_full got %0b exp 1", acc_qready_o); else passed++;
    @(negedge clk_i);
    present(1'b0, 32'd0, 5'd0, 32'd0);
    total++; if ({start_o, acc_pvalid_o} !== 2'b11)
      $display("FAIL ar_setup got s%0b v%0b exp s1 v1", start_o, acc_pvalid_o); else passed++;
    #2 rst_ni = 1'b0;
    #1;
    total++; if (acc_pvalid_o !== 1'b0) $display("FAIL ar_pvalid got %0b exp 0", acc_pvalid_o); else passed++;
    total++; if (start_o !== 1'b0) $display("FAIL ar_start got %0b exp 0", start_o); else passed++;
    total++; if (csr_o !== 224'd0) $display("FAIL ar_csr got %h exp 0", csr_o); else passed++;
    total++; if (acc_pid_o !== 5'd0) $display("FAIL ar_pid got %0d exp 0", acc_pid_o); else passed++;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    total++; if ({acc_pvalid_o, start_o} !== 2'b00)
      $display("FAIL ar_after got v%0b s%0b exp v0 s0", acc_pvalid_o, start_o); else passed++;
  endtask

  initial begin
    rst_ni       = 1'b0;
    acc_pready_i = 1'b0;
    acc_busy_i   = 1'b0;
    present(1'b0, 32'd0, 5'd0, 32'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    test_reset;
    test_write_read;
    test_start;
    test_errors;
    test_busy_write;
    test_backpressure;
    test_back_to_back;
    test_async_reset;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
